// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
//   Instruction-memory fetch bus between the fetch unit and instruction memory.
//   A transfer completes on any rising edge where imem_req_o and imem_ack_i are
//   both high; the acknowledge may arrive in the same cycle as the request.
//
//   imem_req_o    fetch unit -> memory   request, held until acknowledged
//   imem_addr_o   fetch unit -> memory   word address, stable while requesting
//   imem_ack_i    memory -> fetch unit   transfer complete this cycle
//   imem_rdata_i  memory -> fetch unit   instruction word, valid with ack
//
//   master : the fetch unit
//   slave  : the instruction memory
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_ack_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_ack_i,
      output imem_rdata_i
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   Upstream stage of the control unit. Holds the PC, fetches 32-bit words
//   over the imem req/ack bus and presents each word with its PC in an IF/ID
//   output register. Supports a decode stall, a one-entry skid buffer and
//   branch/jump redirect with a squash of any stale in-flight fetch.
//
//   Ports
//     clk            rising-edge clock
//     reset          asynchronous, active-high reset
//     imem           fetch bus (master side): req/addr out, ack/rdata in
//     stall_i        decode cannot accept; output register holds
//     redirect_i     one-cycle pulse: taken branch/jump, squash and refetch
//     redirect_pc_i  redirect target (bits [1:0] ignored)
//     inst_o         instruction to decode; NOP_INST when not valid
//     pc_o           PC of inst_o
//     pc_plus4_o     pc_o + 4, wrapping modulo 2^32
//     inst_valid_o   inst_o/pc_o hold a real instruction
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic                            clk,
   input  logic                            reset,
   instruction_fetch_unit_if.master        imem,
   input  logic                            stall_i,
   input  logic                            redirect_i,
   input  logic [31:0]                     redirect_pc_i,
   output logic [31:0]                     inst_o,
   output logic [31:0]                     pc_o,
   output logic [31:0]                     pc_plus4_o,
   output logic                            inst_valid_o
);

   // FETCH : request outstanding (or about to be issued), words flow to output
   // HOLD  : a word sits in the skid buffer, no request until decode drains
   // DROP  : a stale request must finish before fetching the redirect target
   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DROP  = 2'd2
   } state_e;

   state_e      state_q,      state_d;
   logic [31:0] pc_q,         pc_d;
   logic [31:0] addr_q,       addr_d;
   logic        req_q,        req_d;
   logic [31:0] skid_inst_q,  skid_inst_d;
   logic [31:0] skid_pc_q,    skid_pc_d;
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] out_inst_q,   out_inst_d;
   logic [31:0] out_pc_q,     out_pc_d;
   logic        out_valid_q,  out_valid_d;

   logic        ack;
   logic        out_free;
   logic        out_consume;
   logic [31:0] target_pc;
   logic [31:0] pc_next;

   // An ack only counts while our own request is asserted; this also makes
   // acks arriving during or just after reset harmless.
   assign ack         = req_q & imem.imem_ack_i;
   assign out_consume = out_valid_q & ~stall_i;
   assign out_free    = ~out_valid_q | ~stall_i;
   assign target_pc   = redirect_pc_i & ~32'h3;
   assign pc_next     = pc_q + 32'd4;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      addr_d       = addr_q;
      req_d        = req_q;
      skid_inst_d  = skid_inst_q;
      skid_pc_d    = skid_pc_q;
      skid_valid_d = skid_valid_q;
      out_inst_d   = out_inst_q;
      out_pc_d     = out_pc_q;
      out_valid_d  = out_valid_q;

      if (redirect_i) begin
         // Redirect outranks stall: the output register and skid are squashed
         // and any word acked in this same cycle is thrown away.
         pc_d         = target_pc;
         out_valid_d  = 1'b0;
         out_inst_d   = NOP_INST;
         skid_valid_d = 1'b0;
         case (state_q)
            ST_FETCH: begin
               if (ack || !req_q) begin
                  // Nothing left in flight: start at the target right away.
                  state_d = ST_FETCH;
                  req_d   = 1'b1;
                  addr_d  = target_pc;
               end else begin
                  // Request still pending at the old address; let it finish
                  // unchanged, then discard its data.
                  state_d = ST_DROP;
               end
            end
            ST_HOLD: begin
               state_d = ST_FETCH;
               req_d   = 1'b1;
               addr_d  = target_pc;
            end
            ST_DROP: begin
               if (ack) begin
                  state_d = ST_FETCH;
                  req_d   = 1'b1;
                  addr_d  = target_pc;
               end
            end
            default: begin
               state_d = ST_FETCH;
               req_d   = 1'b1;
               addr_d  = target_pc;
            end
         endcase
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (!req_q) begin
                  // First cycle after reset: launch the initial request.
                  req_d  = 1'b1;
                  addr_d = pc_q;
               end else if (ack) begin
                  pc_d = pc_next;
                  if (out_free) begin
                     out_inst_d  = imem.imem_rdata_i;
                     out_pc_d    = addr_q;
                     out_valid_d = 1'b1;
                     // Back-to-back request keeps zero-wait memory at 1/cycle.
                     addr_d      = pc_next;
                  end else begin
                     skid_inst_d  = imem.imem_rdata_i;
                     skid_pc_d    = addr_q;
                     skid_valid_d = 1'b1;
                     req_d        = 1'b0;
                     state_d      = ST_HOLD;
                  end
               end else if (out_consume) begin
                  out_valid_d = 1'b0;
                  out_inst_d  = NOP_INST;
               end
            end
            ST_HOLD: begin
               if (!stall_i) begin
                  out_inst_d   = skid_valid_q ? skid_inst_q : NOP_INST;
                  out_pc_d     = skid_pc_q;
                  out_valid_d  = skid_valid_q;
                  skid_valid_d = 1'b0;
                  state_d      = ST_FETCH;
                  req_d        = 1'b1;
                  addr_d       = pc_q;
               end
            end
            ST_DROP: begin
               // Output is already invalid here; only wait out the stale ack.
               if (ack) begin
                  state_d = ST_FETCH;
                  req_d   = 1'b1;
                  addr_d  = pc_q;
               end
            end
            default: begin
               state_d = ST_FETCH;
               req_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_FETCH;
         pc_q         <= RESET_PC;
         addr_q       <= RESET_PC;
         req_q        <= 1'b0;
         skid_inst_q  <= NOP_INST;
         skid_pc_q    <= '0;
         skid_valid_q <= 1'b0;
         out_inst_q   <= NOP_INST;
         out_pc_q     <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         addr_q       <= addr_d;
         req_q        <= req_d;
         skid_inst_q  <= skid_inst_d;
         skid_pc_q    <= skid_pc_d;
         skid_valid_q <= skid_valid_d;
         out_inst_q   <= out_inst_d;
         out_pc_q     <= out_pc_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign imem.imem_req_o  = req_q;
   assign imem.imem_addr_o = addr_q;
   assign inst_o           = out_inst_q;
   assign pc_o             = out_pc_q;
   assign pc_plus4_o       = out_pc_q + 32'd4;
   assign inst_valid_o     = out_valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] BASE = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic [31:0] inst_o, pc_o, pc_plus4_o;
   logic        inst_valid_o;

   instruction_fetch_unit_if bus ();

   instruction_fetch_unit #(
      .RESET_PC (32'h0040_0000),
      .NOP_INST (32'h0000_0013)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .imem          (bus.master),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .inst_o        (inst_o),
      .pc_o          (pc_o),
      .pc_plus4_o    (pc_plus4_o),
      .inst_valid_o  (inst_valid_o)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- memory model ----------------
   int unsigned mem_lat = 0;
   int unsigned cnt;
   logic        mem_en = 1'b1;
   logic        force_ack = 1'b0;
   logic [31:0] force_data = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A00_0000;
   endfunction

   assign bus.imem_ack_i   = force_ack | (mem_en & bus.imem_req_o & (cnt >= mem_lat));
   assign bus.imem_rdata_i = force_ack ? force_data : mem_word(bus.imem_addr_o);

   always @(posedge clk or posedge reset) begin
      if (reset)                                  cnt <= 0;
      else if (bus.imem_req_o && bus.imem_ack_i)  cnt <= 0;
      else if (bus.imem_req_o)                    cnt <= cnt + 1;
   end

   // ---------------- check helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_valid(input string name);
      bit seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (inst_valid_o) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: timeout waiting for inst_valid_o, got 0 expected 1", name);
      end
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      stall_i    = 1'b0;
      redirect_i = 1'b0;
      mem_en     = 1'b1;
      force_ack  = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // ---------------- scoreboard ----------------
   logic        sb_en = 1'b0;
   logic [31:0] sb_next;
   logic [31:0] sb_q[$];

   always @(negedge clk) begin
      if (sb_en && !reset) begin
         if (bus.imem_req_o && bus.imem_ack_i) begin
            chk("sb_addr", bus.imem_addr_o, sb_next);
            sb_q.push_back(sb_next);
            sb_next = sb_next + 32'd4;
         end
         if (inst_valid_o && !stall_i) begin
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_underflow: got pc %08h expected no output", pc_o);
            end else begin
               logic [31:0] e;
               e = sb_q.pop_front();
               chk("sb_pc", pc_o, e);
               chk("sb_inst", inst_o, mem_word(e));
               chk("sb_pc4", pc_plus4_o, e + 32'd4);
            end
         end
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic        chk_pc;
   } vec_t;

   vec_t tbl[17];

   initial begin
      // stall redir rpc          req addr          valid pc           chk_pc
      tbl[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
      tbl[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0040_0000, 1'b0, 32'h0,        1'b0};
      tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0040_0004, 1'b1, 32'h0040_0000, 1'b1};
      tbl[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0040_0008, 1'b1, 32'h0040_0004, 1'b1};
      tbl[4]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0040_0004, 1'b1};
      tbl[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0040_0004, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0040_0004, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0040_000C, 1'b1, 32'h0040_0008, 1'b1};
      tbl[8]  = '{1'b1, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_000C, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0040_0200, 1'b0, 32'h0,        1'b0};
      tbl[10] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0040_0204, 1'b1, 32'h0040_0200, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,        1'b0};
      tbl[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 1'b1};
      tbl[13] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b1};
      tbl[14] = '{1'b1, 1'b1, 32'h0040_0300, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b1};
      tbl[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0040_0300, 1'b0, 32'h0,        1'b0};
      tbl[16] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0040_0304, 1'b1, 32'h0040_0300, 1'b1};

      // ---- table run, zero-wait memory ----
      mem_lat = 0;
      do_reset();
      for (int i = 0; i < 17; i++) begin
         stall_i       = tbl[i].stall;
         redirect_i    = tbl[i].redir;
         redirect_pc_i = tbl[i].rpc;
         @(negedge clk);
         chk1($sformatf("row%0d_req", i), bus.imem_req_o, tbl[i].e_req);
         if (tbl[i].e_req)
            chk($sformatf("row%0d_addr", i), bus.imem_addr_o, tbl[i].e_addr);
         chk1($sformatf("row%0d_valid", i), inst_valid_o, tbl[i].e_valid);
         chk($sformatf("row%0d_inst", i), inst_o,
             tbl[i].e_valid ? mem_word(tbl[i].e_pc) : NOP);
         if (tbl[i].chk_pc) begin
            chk($sformatf("row%0d_pc", i), pc_o, tbl[i].e_pc);
            chk($sformatf("row%0d_pc4", i), pc_plus4_o, tbl[i].e_pc + 32'd4);
         end
         @(posedge clk); #1;
      end
      stall_i    = 1'b0;
      redirect_i = 1'b0;

      // ---- scoreboard runs with random stall, two memory latencies ----
      for (int pass = 0; pass < 2; pass++) begin
         mem_lat = (pass == 0) ? 0 : 2;
         do_reset();
         sb_q.delete();
         sb_next = BASE;
         sb_en   = 1'b1;
         repeat (200) begin
            stall_i = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
         end
         mem_en  = 1'b0;
         stall_i = 1'b0;
         for (int k = 0; k < 10 && sb_q.size() != 0; k++) begin
            @(posedge clk); #1;
         end
         chk("sb_drain", 32'(sb_q.size()), 32'd0);
         sb_en  = 1'b0;
         mem_en = 1'b1;
      end

      // ---- redirect while a latency-3 fetch is pending ----
      mem_lat = 3;
      do_reset();
      @(posedge clk); #1;
      chk1("drop_req", bus.imem_req_o, 1'b1);
      chk("drop_addr0", bus.imem_addr_o, 32'h0040_0000);
      @(posedge clk); #1;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0040_0103;
      chk("drop_addr1", bus.imem_addr_o, 32'h0040_0000);
      @(posedge clk); #1;
      redirect_i = 1'b0;
      chk("drop_addr2", bus.imem_addr_o, 32'h0040_0000);
      chk1("drop_valid2", inst_valid_o, 1'b0);
      @(posedge clk); #1;
      chk("drop_addr3", bus.imem_addr_o, 32'h0040_0000);
      @(posedge clk); #1;
      chk("drop_newaddr", bus.imem_addr_o, 32'h0040_0100);
      chk1("drop_newreq", bus.imem_req_o, 1'b1);
      chk1("drop_valid4", inst_valid_o, 1'b0);
      wait_valid("drop_wait");
      chk("drop_pc", pc_o, 32'h0040_0100);
      chk("drop_inst", inst_o, mem_word(32'h0040_0100));

      // ---- reset during a pending latency-3 fetch ----
      mem_lat = 3;
      do_reset();
      wait_valid("rst_wait0");
      stall_i = 1'b1;
      chk("rst_pre_pc", pc_o, 32'h0040_0000);
      @(posedge clk); #3;
      reset      = 1'b1;
      force_ack  = 1'b1;
      force_data = 32'hDEAD_BEEF;
      #1;
      chk1("rst_req", bus.imem_req_o, 1'b0);
      chk1("rst_valid", inst_valid_o, 1'b0);
      chk("rst_inst", inst_o, NOP);
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_pc4", pc_plus4_o, 32'h4);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      force_ack = 1'b0;
      stall_i   = 1'b0;
      chk1("rst_late_valid", inst_valid_o, 1'b0);
      chk("rst_late_inst", inst_o, NOP);
      chk1("rst_restart_req", bus.imem_req_o, 1'b1);
      chk("rst_restart_addr", bus.imem_addr_o, 32'h0040_0000);
      wait_valid("rst_wait1");
      chk("rst_first_pc", pc_o, 32'h0040_0000);
      chk("rst_first_inst", inst_o, mem_word(32'h0040_0000));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
